// File: rtl/sobel_pkg.sv
// Shared definitions for the grayscale->padding->sobel stream pipeline and its frame sequencer.
package sobel_pkg;

  localparam int unsigned DEF_IMG_WIDTH  = 32'd720;
  localparam int unsigned DEF_IMG_HEIGHT = 32'd540;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } frame_state_t;

  function automatic int unsigned npix(input int unsigned width, input int unsigned height);
    return width * height;
  endfunction

endpackage

// File: rtl/sobel_rd_skid.sv
// Two-entry skid buffer between the 1-cycle-latency input memory and the pipeline input FIFO.
// Credit tracks free slots minus the read still in flight, so the memory never overruns it.
module sobel_rd_skid #(
  parameter int unsigned RGB_DWIDTH = 24
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  rd_issue,
  input  logic [RGB_DWIDTH-1:0] rd_data,
  input  logic                  pop,
  output logic [RGB_DWIDTH-1:0] head,
  output logic                  empty,
  output logic                  credit
);

  logic [RGB_DWIDTH-1:0] mem_r [2];
  logic                  wr_ptr_r;
  logic                  rd_ptr_r;
  logic [1:0]            count_r;
  logic                  inflight_r;
  logic [2:0]            used_s;
  logic [2:0]            avail_s;

  // A pop in the same cycle frees a slot in time for the read issued now.
  assign used_s  = {1'b0, count_r} + {2'b00, inflight_r};
  assign avail_s = 3'd2 + {2'b00, pop};
  assign credit  = (used_s < avail_s);
  assign empty   = (count_r == 2'd0);
  assign head    = mem_r[rd_ptr_r];

  // Storage, pointers, occupancy and in-flight flag; flush drops any landing read.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      mem_r[0]   <= {RGB_DWIDTH{1'b0}};
      mem_r[1]   <= {RGB_DWIDTH{1'b0}};
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_issue;
      if (inflight_r) begin
        mem_r[wr_ptr_r] <= rd_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({inflight_r, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: streams one RGB frame from input memory into the sobel pipeline and
// drains the pipeline output into output memory, flagging done or a stall timeout.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH      = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT     = DEF_IMG_HEIGHT,
  parameter int unsigned RGB_DWIDTH     = 24,
  parameter int unsigned SOBEL_DWIDTH   = 8,
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   in_rd_addr,
  output logic                    in_rd_en,
  input  logic [RGB_DWIDTH-1:0]   in_rd_data,
  output logic                    fifo_in_wr_en,
  output logic [RGB_DWIDTH-1:0]   fifo_in_din,
  input  logic                    fifo_in_full,
  output logic                    fifo_out_rd_en,
  input  logic [SOBEL_DWIDTH-1:0] fifo_out_dout,
  input  logic                    fifo_out_empty,
  output logic                    out_wr_en,
  output logic [ADDR_WIDTH-1:0]   out_wr_addr,
  output logic [SOBEL_DWIDTH-1:0] out_wr_data
);

  localparam int unsigned         NPIX     = npix(IMG_WIDTH, IMG_HEIGHT);
  localparam int unsigned         TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [ADDR_WIDTH-1:0] NPIX_A = ADDR_WIDTH'(NPIX);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(0);
  localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [TW-1:0]       ONE_T    = TW'(1);
  localparam logic [TW-1:0]       ZERO_T   = TW'(0);

  frame_state_t          state_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  error_r;
  logic [ADDR_WIDTH-1:0] rd_cnt_r;
  logic [ADDR_WIDTH-1:0] out_cnt_r;
  logic [TW-1:0]         timer_r;

  logic                  run_s;
  logic                  start_ok_s;
  logic                  flush_s;
  logic                  rd_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  credit_s;
  logic                  skid_empty_s;
  logic [RGB_DWIDTH-1:0] skid_head_s;

  assign run_s      = (state_r == ST_RUN);
  assign start_ok_s = start && !abort && !run_s;
  assign flush_s    = abort || start_ok_s;
  assign rd_s       = run_s && (rd_cnt_r < NPIX_A) && credit_s;
  assign push_s     = run_s && !skid_empty_s && !fifo_in_full;
  assign pop_s      = run_s && !fifo_out_empty;

  assign busy           = busy_r;
  assign done           = done_r;
  assign error          = error_r;
  assign in_rd_en       = rd_s;
  assign in_rd_addr     = rd_cnt_r;
  assign fifo_in_wr_en  = push_s;
  assign fifo_in_din    = push_s ? skid_head_s : {RGB_DWIDTH{1'b0}};
  assign fifo_out_rd_en = pop_s;
  assign out_wr_en      = pop_s;
  assign out_wr_addr    = out_cnt_r;
  assign out_wr_data    = pop_s ? fifo_out_dout : {SOBEL_DWIDTH{1'b0}};

  sobel_rd_skid #(
    .RGB_DWIDTH (RGB_DWIDTH)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush_s),
    .rd_issue (rd_s),
    .rd_data  (in_rd_data),
    .pop      (push_s),
    .head     (skid_head_s),
    .empty    (skid_empty_s),
    .credit   (credit_s)
  );

  // Frame FSM with its address counters, stall watchdog and status flags.
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      rd_cnt_r  <= ZERO_A;
      out_cnt_r <= ZERO_A;
      timer_r   <= ZERO_T;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (rd_s) begin
            rd_cnt_r <= rd_cnt_r + ONE_A;
          end
          if (pop_s) begin
            out_cnt_r <= out_cnt_r + ONE_A;
            timer_r   <= ZERO_T;
          end else begin
            timer_r <= timer_r + ONE_T;
          end
          // The watchdog fires as the timer steps onto TIMEOUT_CYCLES-1.
          if (pop_s && (out_cnt_r == LAST_A)) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else if (!pop_s && (timer_r == TMO_LAST)) begin
            state_r <= ST_ERROR;
            busy_r  <= 1'b0;
            error_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_r   <= ST_RUN;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            rd_cnt_r  <= ZERO_A;
            out_cnt_r <= ZERO_A;
            timer_r   <= ZERO_T;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          error_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl: memory + FIFO/identity pipeline environment, random frames,
// reference expectations derived from the frame contents, independent monitor comparing DUT strobes.
module tb_sobel_frame_ctrl;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;
  localparam int TMO  = 64;
  localparam int AW   = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, error;
  logic [AW-1:0] in_rd_addr;
  logic          in_rd_en;
  logic [23:0]   in_rd_data = 24'd0;
  logic          fifo_in_wr_en;
  logic [23:0]   fifo_in_din;
  logic          fifo_in_full;
  logic          fifo_out_rd_en;
  logic [7:0]    fifo_out_dout;
  logic          fifo_out_empty;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic [7:0]    out_wr_data;

  sobel_frame_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .RGB_DWIDTH(24), .SOBEL_DWIDTH(8),
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error),
    .in_rd_addr(in_rd_addr), .in_rd_en(in_rd_en), .in_rd_data(in_rd_data),
    .fifo_in_wr_en(fifo_in_wr_en), .fifo_in_din(fifo_in_din), .fifo_in_full(fifo_in_full),
    .fifo_out_rd_en(fifo_out_rd_en), .fifo_out_dout(fifo_out_dout), .fifo_out_empty(fifo_out_empty),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int mode = 0;            // 0 free-running, 1 backpressure, 2 sparse output, 3 output stall
  int run_cyc = 0;
  int pops_run = 0;
  logic phase = 1'b0;
  logic [23:0] mem [0:15];
  logic [23:0] pq [0:63];
  int pq_wp = 0;
  int pq_rp = 0;

  logic [AW-1:0] rd_exp_q[$];
  logic [23:0]   in_exp_q[$];
  logic [15:0]   out_exp_q[$];
  int rd_n = 0, wr_n = 0, pop_n = 0, last_pop_cyc = 0;

  assign fifo_in_full   = (mode == 1) && (run_cyc >= 3) && (run_cyc <= 10);
  assign fifo_out_empty = (pq_wp == pq_rp) || ((mode == 2) && phase) || ((mode == 3) && (pops_run >= 5));
  assign fifo_out_dout  = pq[pq_rp % 64][7:0];

  // Environment: synchronous-read input memory and a FIFO/identity pipeline.
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    phase <= ~phase;
    run_cyc  <= (start && !busy) ? 0 : run_cyc + 1;
    pops_run <= (start && !busy) ? 0 : pops_run + (fifo_out_rd_en ? 1 : 0);
    if (in_rd_en) in_rd_data <= mem[in_rd_addr[3:0]];
    if (reset || abort) begin
      pq_wp <= 0;
      pq_rp <= 0;
    end else begin
      if (fifo_in_wr_en) begin
        pq[pq_wp % 64] <= fifo_in_din;
        pq_wp <= pq_wp + 1;
      end
      if (fifo_out_rd_en) pq_rp <= pq_rp + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected DUT strobe with empty scoreboard (t=%0t)", nm, $time);
  endtask

  // Monitor: every DUT strobe is matched against the scoreboard queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (fifo_in_wr_en) begin
        wr_n++;
        chk("push_while_full", fifo_in_full, 1'b0);
        if (in_exp_q.size() == 0) flag("push_extra");
        else chk("fifo_in_din", fifo_in_din, in_exp_q.pop_front());
      end
      if (in_rd_en) begin
        rd_n++;
        if (rd_exp_q.size() == 0) flag("read_extra");
        else chk("in_rd_addr", in_rd_addr, rd_exp_q.pop_front());
        chk("skid_bound", ((rd_n - wr_n) > 2) ? 1 : 0, 0);
      end
      if (out_wr_en) begin
        pop_n++;
        last_pop_cyc = cyc;
        chk("rd_en_eq_wr_en", fifo_out_rd_en, 1'b1);
        if (out_exp_q.size() == 0) flag("write_extra");
        else chk("out_write", {out_wr_addr, out_wr_data}, out_exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_sb();
    rd_exp_q.delete();
    in_exp_q.delete();
    out_exp_q.delete();
  endtask

  // Reference: a frame reads addresses 0..NPIX-1 in order and writes pixel i's identity at address i.
  task automatic load_frame();
    clear_sb();
    rd_n = 0; wr_n = 0; pop_n = 0;
    for (int i = 0; i < NPIX; i++) begin
      mem[i] = 24'($urandom);
      rd_exp_q.push_back(AW'(i));
      in_exp_q.push_back(mem[i]);
      out_exp_q.push_back({AW'(i), mem[i][7:0]});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_quiet(input string nm);
    @(negedge clock);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
    chk({nm, "_error"}, error, 1'b0);
    chk({nm, "_strobes"}, {in_rd_en, fifo_in_wr_en, fifo_out_rd_en, out_wr_en}, 4'd0);
    chk({nm, "_data"}, {in_rd_addr, fifo_in_din, out_wr_addr, out_wr_data}, 48'd0);
    tick();
  endtask

  task automatic wait_done(input string nm);
    logic got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      got = done;
    end
    chk({nm, "_done_reached"}, got, 1'b1);
    chk({nm, "_busy_after_done"}, busy, 1'b0);
    chk({nm, "_writes"}, pop_n, NPIX);
    chk({nm, "_pending"}, rd_exp_q.size() + in_exp_q.size() + out_exp_q.size(), 0);
    tick();
    tick();
    @(negedge clock);
    chk({nm, "_done_held"}, {done, busy, in_rd_en, out_wr_en}, 4'b1000);
    tick();
  endtask

  initial begin
    int quiet;
    logic got;
    repeat (3) tick();
    check_quiet("reset");
    reset = 1'b0;
    tick();

    mode = 0; load_frame(); pulse_start(); wait_done("nominal");
    load_frame(); pulse_start(); wait_done("restart_from_done");
    mode = 1; load_frame(); pulse_start(); wait_done("backpressure");
    mode = 2; load_frame(); pulse_start(); wait_done("sparse");

    mode = 3; load_frame(); pulse_start();
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clock);
      got = error;
    end
    chk("tmo_error_reached", got, 1'b1);
    chk("tmo_latency", cyc - last_pop_cyc, TMO);
    chk("tmo_pops", pop_n, 5);
    chk("tmo_flags", {busy, done}, 2'b00);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      quiet += int'(in_rd_en) + int'(fifo_in_wr_en) + int'(out_wr_en);
    end
    chk("tmo_strobes_after_error", quiet, 0);
    chk("tmo_error_held", error, 1'b1);
    tick();
    reset = 1'b1; mode = 0; clear_sb();
    tick();
    reset = 1'b0;
    check_quiet("tmo_reset");

    load_frame(); pulse_start();
    repeat (6) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    clear_sb();
    check_quiet("abort");
    load_frame(); pulse_start(); wait_done("after_abort");

    load_frame(); pulse_start();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("start_in_run_busy", busy, 1'b1);
    reset = 1'b1;
    clear_sb();
    tick();
    @(negedge clock);
    chk("reset_mid_run_strobes", {busy, in_rd_en, fifo_in_wr_en, out_wr_en}, 4'd0);
    tick();
    reset = 1'b0;
    check_quiet("reset_mid_run");
    load_frame(); pulse_start(); wait_done("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
